// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall / flush / forwarding controller for a 5-stage MIPS pipeline.
//   Produces load enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also
//   produces bubble-load flushes for IF/ID and ID/EX, and the EX-stage operand
//   forwarding selects. It handles:
//     - load-use hazards
//     - taken-branch squashes
//     - data-memory wait states, with an optional timeout
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt      source operands of the instruction in ID
//   ex_rs, ex_rt, ex_rd           operands / destination held in ID/EX
//   ex_wreg, ex_m2reg             ID/EX writes regfile / is a load
//   mem_rd, mem_wreg              EX/MEM destination / write flag
//   wb_rd, wb_wreg                MEM/WB destination / write flag
//   br_taken                      branch in EX resolved taken
//   dmem_req, dmem_ready          MEM-stage access active / completing
//   pc_en .. memwb_en             register load enables (combinational)
//   ifid_flush, idex_flush        load a bubble this edge (combinational)
//   fwd_a, fwd_b                  00 regfile, 01 EX/MEM, 10 MEM/WB
//   mem_err                       sticky data-memory timeout flag
//   stall_cycles                  count of cycles with pc_en=0
//
// Parameters
//   WAIT_MAX  wait cycles tolerated before timeout (0 disables the timeout)
//   WAIT_W    wait counter width; it must hold WAIT_MAX
//   CNT_W     stall_cycles width
//
// Build option
//   STALL_CNT_EN  when defined, stall_cycles is a saturating counter.
//                 When undefined, stall_cycles is tied to zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal flow; branch / load-use rules apply
// ST_MWAIT | data memory busy; whole pipeline frozen
// ST_ERR   | memory timed out; pipeline frozen until reset

module pipeline_hazard_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int WAIT_W   = 4,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_rd,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [4:0]       mem_rd,
   input  logic             mem_wreg,
   input  logic [4:0]       wb_rd,
   input  logic             wb_wreg,
   input  logic             br_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MWAIT = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   localparam logic [WAIT_W-1:0] WAIT_MAX_W = WAIT_W'(WAIT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                mem_err_q, mem_err_d;
   logic                load_use;

   // $zero is never a real dependency, so a load targeting r0 never stalls.
   assign load_use = ex_m2reg && ex_wreg && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] m_rd,
                                          input logic       m_wreg,
                                          input logic [4:0] w_rd,
                                          input logic       w_wreg);
      logic [1:0] sel;
      sel = 2'b00;
      if (m_wreg && (m_rd != 5'd0) && (m_rd == src))
         sel = 2'b01;
      else if (w_wreg && (w_rd != 5'd0) && (w_rd == src))
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      fwd_a      = fwd_sel(ex_rs, mem_rd, mem_wreg, wb_rd, wb_wreg);
      fwd_b      = fwd_sel(ex_rt, mem_rd, mem_wreg, wb_rd, wb_wreg);

      if (rst) begin
         // Load bubbles everywhere while reset is held.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         fwd_a      = 2'b00;
         fwd_b      = 2'b00;
      end else begin
         // The freeze flag selects the all-enables-off response. When the
         // pipeline is not frozen, the normal branch / load-use rules apply.
         logic freeze;
         freeze = 1'b0;
         unique case (state_q)
            ST_RUN: begin
               if (dmem_req && !dmem_ready) begin
                  freeze     = 1'b1;
                  state_d    = ST_MWAIT;
                  wait_cnt_d = WAIT_ONE;
               end
            end
            ST_MWAIT: begin
               if (dmem_ready) begin
                  state_d    = ST_RUN;
                  wait_cnt_d = '0;
               end else begin
                  freeze = 1'b1;
                  if ((WAIT_MAX != 0) && (wait_cnt_q == WAIT_MAX_W)) begin
                     state_d   = ST_ERR;
                     mem_err_d = 1'b1;
                  end else begin
                     wait_cnt_d = wait_cnt_q + WAIT_ONE;
                  end
               end
            end
            ST_ERR: begin
               freeze    = 1'b1;
               mem_err_d = 1'b1;
            end
            default: begin
               freeze  = 1'b1;
               state_d = ST_RUN;
            end
         endcase

         if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end else if (br_taken) begin
            // The ID instruction is squashed, so a pending load-use hazard is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = {CNT_W{1'b0}};
`endif

endmodule
